// File: rtl/uart_core_p.sv
// rtl/uart_core_p.sv - parametrised UART TX/RX serial engine with parity, stop-bit and error reporting
//
// Purpose: single-clock UART datapath between valid/ready character streams and the pads.
//   Each direction owns a prescaler that restarts at frame start, so frame timing is exact.
// Parameters: DATA_BITS (5..9) character width, OVS (even, >=4) ticks per bit, DIV_W baud_div width.
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   baud_div                 tick period = baud_div+1 clk cycles
//   parity_en, parity_odd    parity present / odd (else even)
//   stop2                    TX sends two stop bits
//   tx_data/tx_valid/tx_ready  character input, accepted only when idle
//   utxd_o                   serial output, idle high
//   urxd_i                   asynchronous serial input
//   rx_data/rx_valid/rx_ready  received character output
//   rx_parity_err, rx_frame_err  error flags qualified by rx_valid
//   rx_overrun               one-cycle pulse when a completed character is discarded
module uart_core_p #(
    parameter int DATA_BITS = 8,
    parameter int OVS       = 16,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop2,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 utxd_o,
    input  logic                 urxd_i,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int TW = $clog2(OVS);
    localparam int BW = 4;
    localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    // ---------------------------------------------------------------- TX
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_t;

    tx_state_t              tx_state, tx_next;
    logic [DIV_W-1:0]       tx_pre;
    logic [TW-1:0]          tx_tcnt;
    logic [BW-1:0]          tx_bcnt;
    logic [DATA_BITS-1:0]   tx_sh;
    logic                   tx_par;
    logic                   tx_par_en_q;
    logic                   tx_stop2_q;
    logic                   tx_tick;
    logic                   tx_bit_end;
    logic                   tx_accept;

    // >= keeps the prescaler from running away if baud_div shrinks mid-frame
    assign tx_tick    = (tx_pre >= baud_div);
    assign tx_bit_end = tx_tick && (tx_tcnt == T_LAST);
    assign tx_ready   = (tx_state == TX_IDLE);
    assign tx_accept  = tx_valid && tx_ready;

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_valid) tx_next = TX_START;
            TX_START:  if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:   if (tx_bit_end && tx_bcnt == B_LAST)
                           tx_next = tx_par_en_q ? TX_PARITY : TX_STOP1;
            TX_PARITY: if (tx_bit_end) tx_next = TX_STOP1;
            TX_STOP1:  if (tx_bit_end) tx_next = tx_stop2_q ? TX_STOP2 : TX_IDLE;
            TX_STOP2:  if (tx_bit_end) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        utxd_o = 1'b1;
        case (tx_state)
            TX_START:  utxd_o = 1'b0;
            TX_DATA:   utxd_o = tx_sh[0];
            TX_PARITY: utxd_o = tx_par;
            default:   utxd_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state    <= TX_IDLE;
            tx_pre      <= '0;
            tx_tcnt     <= '0;
            tx_bcnt     <= '0;
            tx_sh       <= '0;
            tx_par      <= 1'b0;
            tx_par_en_q <= 1'b0;
            tx_stop2_q  <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_accept) begin
                // frame configuration is frozen here for the whole frame
                tx_pre      <= '0;
                tx_tcnt     <= '0;
                tx_bcnt     <= '0;
                tx_sh       <= tx_data;
                tx_par      <= (^tx_data) ^ parity_odd;
                tx_par_en_q <= parity_en;
                tx_stop2_q  <= stop2;
            end else if (tx_state != TX_IDLE) begin
                if (tx_tick) begin
                    tx_pre  <= '0;
                    tx_tcnt <= tx_bit_end ? '0 : tx_tcnt + TW'(1);
                end else begin
                    tx_pre <= tx_pre + DIV_W'(1);
                end
                if (tx_bit_end && tx_state == TX_DATA) begin
                    tx_sh   <= tx_sh >> 1;
                    tx_bcnt <= tx_bcnt + BW'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------------- RX
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    rx_state_t              rx_state, rx_next;
    logic                   rx_s1, rx_s2, rx_prev;
    logic [DIV_W-1:0]       rx_pre;
    logic [TW-1:0]          rx_tcnt;
    logic [BW-1:0]          rx_bcnt;
    logic [DATA_BITS-1:0]   rx_sh;
    logic                   rx_par_bit;
    logic                   rx_par_en_q;
    logic                   rx_par_odd_q;
    logic                   rx_tick;
    logic                   rx_mid;
    logic                   rx_bit_end;
    logic                   rx_fall;
    logic                   rx_done;
    logic                   rx_perr_n;
    logic                   rx_active;

    assign rx_tick    = (rx_pre >= baud_div);
    assign rx_mid     = rx_tick && (rx_state == RX_START) && (rx_tcnt == T_HALF);
    assign rx_bit_end = rx_tick && (rx_tcnt == T_LAST);
    assign rx_fall    = rx_prev && !rx_s2;
    assign rx_done    = (rx_state == RX_STOP) && rx_bit_end;
    assign rx_perr_n  = rx_par_en_q && (((^rx_sh) ^ rx_par_odd_q) != rx_par_bit);
    assign rx_active  = (rx_state == RX_START) || (rx_state == RX_DATA) ||
                        (rx_state == RX_PARITY) || (rx_state == RX_STOP);

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:      if (rx_fall) rx_next = RX_START;
            RX_START:     if (rx_mid) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_bit_end && rx_bcnt == B_LAST)
                              rx_next = rx_par_en_q ? RX_PARITY : RX_STOP;
            RX_PARITY:    if (rx_bit_end) rx_next = RX_STOP;
            // a low stop bit means the line may still be in a break; wait for idle
            RX_STOP:      if (rx_bit_end) rx_next = rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_s2) rx_next = RX_IDLE;
            default:      rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1         <= 1'b1;
            rx_s2         <= 1'b1;
            rx_prev       <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_pre        <= '0;
            rx_tcnt       <= '0;
            rx_bcnt       <= '0;
            rx_sh         <= '0;
            rx_par_bit    <= 1'b0;
            rx_par_en_q   <= 1'b0;
            rx_par_odd_q  <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_s1      <= urxd_i;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            rx_state   <= rx_next;
            rx_overrun <= 1'b0;

            if (rx_state == RX_IDLE && rx_fall) begin
                rx_pre       <= '0;
                rx_tcnt      <= '0;
                rx_bcnt      <= '0;
                rx_par_en_q  <= parity_en;
                rx_par_odd_q <= parity_odd;
            end else if (rx_active) begin
                if (rx_tick) begin
                    rx_pre  <= '0;
                    rx_tcnt <= (rx_mid || rx_bit_end) ? '0 : rx_tcnt + TW'(1);
                end else begin
                    rx_pre <= rx_pre + DIV_W'(1);
                end
                if (rx_bit_end && rx_state == RX_DATA) begin
                    rx_sh   <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                    rx_bcnt <= rx_bcnt + BW'(1);
                end
                if (rx_bit_end && rx_state == RX_PARITY) begin
                    rx_par_bit <= rx_s2;
                end
            end else begin
                rx_pre  <= '0;
                rx_tcnt <= '0;
            end

            // completion while the old character is still unconsumed drops the new one
            if (rx_done) begin
                if (rx_valid && !rx_ready) begin
                    rx_overrun <= 1'b1;
                end else begin
                    rx_data       <= rx_sh;
                    rx_parity_err <= rx_perr_n;
                    rx_frame_err  <= !rx_s2;
                    rx_valid      <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
